// File: rtl/ada_hazard_unit.sv
// Pipeline hazard unit: tracks EX/MEM/WB destination records, picks operand
// forwarding sources and raises stall/bubble controls, with stall/hazard counters.
module ada_hazard_unit #(
    parameter int unsigned ENABLE_FWD = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_gpr_port_a,
    input  logic [4:0]  id_gpr_port_b,
    input  logic        id_uses_a,
    input  logic        id_uses_b,
    input  logic [4:0]  id_gpr_wa,
    input  logic        id_gpr_we,
    input  logic        id_mem_read,
    input  logic        mem_stall_req,
    input  logic        exc_flush,
    output logic [1:0]  forward_port_a_select,
    output logic [1:0]  forward_port_b_select,
    output logic        if_stall,
    output logic        id_stall,
    output logic        ex_bubble,
    output logic        ex_stall,
    output logic        mem_stall,
    output logic [31:0] stall_cycles,
    output logic [15:0] hazard_events
);

    localparam logic [1:0] SEL_GPR = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b11;

    // Stage record layout: {wa[4:0], we, ld}
    logic [6:0]  ex_q, ex_d;
    logic [6:0]  mem_q, mem_d;
    logic [6:0]  wb_q, wb_d;
    logic        hazard_q;
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] hazard_events_q, hazard_events_d;

    logic hazard;
    logic a_ex, a_mem, a_wb, b_ex, b_mem, b_wb;

    function automatic logic src_match(input logic uses, input logic [4:0] src,
                                       input logic [6:0] rec);
        return uses & rec[1] & (rec[6:2] == src) & (src != 5'd0);
    endfunction

    always_comb begin
        a_ex  = src_match(id_uses_a, id_gpr_port_a, ex_q);
        a_mem = src_match(id_uses_a, id_gpr_port_a, mem_q);
        a_wb  = src_match(id_uses_a, id_gpr_port_a, wb_q);
        b_ex  = src_match(id_uses_b, id_gpr_port_b, ex_q);
        b_mem = src_match(id_uses_b, id_gpr_port_b, mem_q);
        b_wb  = src_match(id_uses_b, id_gpr_port_b, wb_q);
    end

    always_comb begin
        hazard                = 1'b0;
        forward_port_a_select = SEL_GPR;
        forward_port_b_select = SEL_GPR;
        if (ENABLE_FWD != 0) begin
            // A load in EX cannot forward yet; the port falls through to older stages.
            hazard = (a_ex | b_ex) & ex_q[0];
            if (a_ex & ~ex_q[0])      forward_port_a_select = SEL_EX;
            else if (a_mem)           forward_port_a_select = SEL_MEM;
            else if (a_wb)            forward_port_a_select = SEL_WB;
            if (b_ex & ~ex_q[0])      forward_port_b_select = SEL_EX;
            else if (b_mem)           forward_port_b_select = SEL_MEM;
            else if (b_wb)            forward_port_b_select = SEL_WB;
        end else begin
            hazard = a_ex | a_mem | a_wb | b_ex | b_mem | b_wb;
        end
    end

    always_comb begin
        if_stall  = mem_stall_req | hazard;
        id_stall  = mem_stall_req | hazard;
        ex_stall  = mem_stall_req;
        mem_stall = mem_stall_req;
        ex_bubble = hazard & ~mem_stall_req & ~exc_flush;
    end

    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!mem_stall_req) begin
            if (exc_flush) begin
                ex_d  = '0;
                mem_d = '0;
                wb_d  = '0;
            end else begin
                ex_d  = hazard ? 7'd0 : {id_gpr_wa, id_gpr_we, id_mem_read};
                mem_d = ex_q;
                wb_d  = mem_q;
            end
        end
    end

    always_comb begin
        stall_cycles_d  = stall_cycles_q;
        hazard_events_d = hazard_events_q;
        if (id_stall && stall_cycles_q != '1)
            stall_cycles_d = stall_cycles_q + 32'd1;
        if (hazard && !hazard_q && hazard_events_q != '1)
            hazard_events_d = hazard_events_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q            <= '0;
            mem_q           <= '0;
            wb_q            <= '0;
            hazard_q        <= 1'b0;
            stall_cycles_q  <= '0;
            hazard_events_q <= '0;
        end else begin
            ex_q            <= ex_d;
            mem_q           <= mem_d;
            wb_q            <= wb_d;
            hazard_q        <= hazard;
            stall_cycles_q  <= stall_cycles_d;
            hazard_events_q <= hazard_events_d;
        end
    end

    assign stall_cycles  = stall_cycles_q;
    assign hazard_events = hazard_events_q;

endmodule

// File: tb/tb_ada_hazard_unit.sv
// Scoreboard bench for ada_hazard_unit: a forwarding instance and a
// non-forwarding instance share stimulus; the monitor checks queued expectations.
module tb_ada_hazard_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  ra = '0, rb = '0, wa = '0;
    logic        ua = 1'b0, ub = 1'b0, we = 1'b0, ld = 1'b0, ms = 1'b0, fl = 1'b0;

    logic [1:0]  f_sa, f_sb, n_sa, n_sb;
    logic        f_ifs, f_ids, f_bub, f_exs, f_mems;
    logic        n_ifs, n_ids, n_bub, n_exs, n_mems;
    logic [31:0] f_sc, n_sc;
    logic [15:0] f_he, n_he;

    ada_hazard_unit #(.ENABLE_FWD(1)) u_fwd (
        .clk(clk), .rst(rst),
        .id_gpr_port_a(ra), .id_gpr_port_b(rb), .id_uses_a(ua), .id_uses_b(ub),
        .id_gpr_wa(wa), .id_gpr_we(we), .id_mem_read(ld),
        .mem_stall_req(ms), .exc_flush(fl),
        .forward_port_a_select(f_sa), .forward_port_b_select(f_sb),
        .if_stall(f_ifs), .id_stall(f_ids), .ex_bubble(f_bub),
        .ex_stall(f_exs), .mem_stall(f_mems),
        .stall_cycles(f_sc), .hazard_events(f_he)
    );

    ada_hazard_unit #(.ENABLE_FWD(0)) u_nofwd (
        .clk(clk), .rst(rst),
        .id_gpr_port_a(ra), .id_gpr_port_b(rb), .id_uses_a(ua), .id_uses_b(ub),
        .id_gpr_wa(wa), .id_gpr_we(we), .id_mem_read(ld),
        .mem_stall_req(ms), .exc_flush(fl),
        .forward_port_a_select(n_sa), .forward_port_b_select(n_sb),
        .if_stall(n_ifs), .id_stall(n_ids), .ex_bubble(n_bub),
        .ex_stall(n_exs), .mem_stall(n_mems),
        .stall_cycles(n_sc), .hazard_events(n_he)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic        nf;
        logic [1:0]  sa, sb;
        logic        st, bub, xs;
        logic [31:0] sc;
        logic [15:0] he;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   vec_idx = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one ID-stage cycle and queue the hand-computed response.
    task automatic vec(input logic [4:0] i_ra, input logic i_ua, input logic [4:0] i_rb,
                       input logic i_ub, input logic [4:0] i_wa, input logic i_we,
                       input logic i_ld, input logic i_ms, input logic i_fl,
                       input logic nf, input logic [1:0] sa, input logic [1:0] sb,
                       input logic st, input logic bub,
                       input logic [31:0] sc, input logic [15:0] he);
        exp_t e;
        @(posedge clk);
        #1;
        ra = i_ra; ua = i_ua; rb = i_rb; ub = i_ub;
        wa = i_wa; we = i_we; ld = i_ld; ms = i_ms; fl = i_fl;
        e.idx = vec_idx; e.nf = nf; e.sa = sa; e.sb = sb; e.st = st; e.bub = bub;
        e.xs = i_ms; e.sc = sc; e.he = he;
        q.push_back(e);
        vec_idx++;
    endtask

    always @(negedge clk) begin
        while (q.size() != 0) begin
            exp_t e;
            logic [1:0]  sa, sb;
            logic        ifs, ids, bub, exs, mems;
            logic [31:0] sc;
            logic [15:0] he;
            e = q.pop_front();
            if (e.nf) begin
                sa = n_sa; sb = n_sb; ifs = n_ifs; ids = n_ids; bub = n_bub;
                exs = n_exs; mems = n_mems; sc = n_sc; he = n_he;
            end else begin
                sa = f_sa; sb = f_sb; ifs = f_ifs; ids = f_ids; bub = f_bub;
                exs = f_exs; mems = f_mems; sc = f_sc; he = f_he;
            end
            vectors++;
            if (sa !== e.sa || sb !== e.sb || ifs !== e.st || ids !== e.st ||
                bub !== e.bub || exs !== e.xs || mems !== e.xs ||
                sc !== e.sc || he !== e.he) begin
                miscompares++;
                $display("FAIL vec%0d(nf=%0d): got sa=%b sb=%b if=%b id=%b bub=%b ex/mem=%b%b sc=%0d he=%0d expected sa=%b sb=%b stall=%b bub=%b ex/mem=%b sc=%0d he=%0d",
                         e.idx, e.nf, sa, sb, ifs, ids, bub, exs, mems, sc, he,
                         e.sa, e.sb, e.st, e.bub, e.xs, e.sc, e.he);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #3;
        chk("rst_sel_a", {30'd0, f_sa}, 32'd0);
        chk("rst_stall", {31'd0, f_ids}, 32'd0);
        chk("rst_sc", f_sc, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;

        //   ra ua rb ub wa we ld ms fl  nf sa     sb     st bub sc he
        // ALU chain: r3 forwarded from EX, MEM, WB
        vec(0, 0, 0, 0, 3, 1, 0, 0, 0,  0, 2'b00, 2'b00, 0, 0, 0, 0);
        vec(3, 1, 0, 0, 0, 0, 0, 0, 0,  0, 2'b01, 2'b00, 0, 0, 0, 0);
        vec(3, 1, 0, 0, 0, 0, 0, 0, 0,  0, 2'b10, 2'b00, 0, 0, 0, 0);
        vec(3, 1, 0, 0, 0, 0, 0, 0, 0,  0, 2'b11, 2'b00, 0, 0, 0, 0);
        vec(3, 1, 0, 0, 0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 0, 0, 0, 0);
        // Memory freeze for 3 cycles with r3 in EX
        vec(0, 0, 0, 0, 3, 1, 0, 0, 0,  0, 2'b00, 2'b00, 0, 0, 0, 0);
        vec(3, 1, 0, 0, 0, 0, 0, 1, 0,  0, 2'b01, 2'b00, 1, 0, 0, 0);
        vec(3, 1, 0, 0, 0, 0, 0, 1, 0,  0, 2'b01, 2'b00, 1, 0, 1, 0);
        vec(3, 1, 0, 0, 0, 0, 0, 1, 0,  0, 2'b01, 2'b00, 1, 0, 2, 0);
        vec(3, 1, 0, 0, 0, 0, 0, 0, 0,  0, 2'b01, 2'b00, 0, 0, 3, 0);
        vec(3, 1, 0, 0, 0, 0, 0, 0, 0,  0, 2'b10, 2'b00, 0, 0, 3, 0);
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 0, 0, 3, 0);
        // Load-use on port B: one stall, then MEM forward
        vec(0, 0, 0, 0, 5, 1, 1, 0, 0,  0, 2'b00, 2'b00, 0, 0, 3, 0);
        vec(0, 0, 5, 1, 0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 1, 1, 3, 0);
        vec(0, 0, 5, 1, 0, 0, 0, 0, 0,  0, 2'b00, 2'b10, 0, 0, 4, 1);
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 0, 0, 4, 1);
        // r0 never matches
        vec(0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 2'b00, 2'b00, 0, 0, 4, 1);
        vec(0, 1, 0, 1, 0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 0, 0, 4, 1);
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 0, 0, 4, 1);
        // Load in EX while older ALU write of r6 sits in MEM: stall, select MEM
        vec(0, 0, 0, 0, 6, 1, 0, 0, 0,  0, 2'b00, 2'b00, 0, 0, 4, 1);
        vec(6, 1, 0, 0, 6, 1, 1, 0, 0,  0, 2'b01, 2'b00, 0, 0, 4, 1);
        vec(6, 1, 0, 0, 0, 0, 0, 0, 0,  0, 2'b10, 2'b00, 1, 1, 4, 1);
        vec(6, 1, 0, 0, 0, 0, 0, 0, 0,  0, 2'b10, 2'b00, 0, 0, 5, 2);
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 0, 0, 5, 2);
        // Flush coincident with load-use hazard
        vec(0, 0, 0, 0, 5, 1, 1, 0, 0,  0, 2'b00, 2'b00, 0, 0, 5, 2);
        vec(0, 0, 5, 1, 0, 0, 0, 0, 1,  0, 2'b00, 2'b00, 1, 0, 5, 2);
        vec(0, 0, 5, 1, 0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 0, 0, 6, 3);

        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_sc", f_sc, 32'd0);
        chk("async_rst_he", {16'd0, f_he}, 32'd0);
        chk("async_rst_sel_b", {30'd0, f_sb}, 32'd0);
        ms = 1'b1;
        #1;
        chk("rst_memstall", {31'd0, f_ids}, 32'd1);
        ms = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;

        // No forwarding: r7 dependency stalls for 3 cycles
        vec(0, 0, 0, 0, 7, 1, 0, 0, 0,  1, 2'b00, 2'b00, 0, 0, 0, 0);
        vec(7, 1, 0, 0, 0, 0, 0, 0, 0,  1, 2'b00, 2'b00, 1, 1, 0, 0);
        vec(7, 1, 0, 0, 0, 0, 0, 0, 0,  1, 2'b00, 2'b00, 1, 1, 1, 1);
        vec(7, 1, 0, 0, 0, 0, 0, 0, 0,  1, 2'b00, 2'b00, 1, 1, 2, 1);
        vec(7, 1, 0, 0, 0, 0, 0, 0, 0,  1, 2'b00, 2'b00, 0, 0, 3, 1);
        vec(0, 0, 0, 0, 7, 1, 0, 0, 0,  1, 2'b00, 2'b00, 0, 0, 3, 1);
        vec(7, 1, 0, 0, 0, 0, 0, 0, 0,  1, 2'b00, 2'b00, 1, 1, 3, 1);

        // Reset mid-stall clears the records with no clock edge
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midstall_rst_stall", {31'd0, n_ids}, 32'd0);
        chk("midstall_rst_sc", n_sc, 32'd0);
        chk("midstall_rst_he", {16'd0, n_he}, 32'd0);

        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) chk("queue_drain", q.size(), 32'd0);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ada_hazard_unit.md
ADA_HAZARD_UNIT -- requirements
Module: ada_hazard_unit

Interface
REQ-001 Parameter ENABLE_FWD, default 1: 1 enables operand forwarding; 0 disables it, so any register dependency stalls.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 id_gpr_port_a  input  5  ID source register A.
REQ-005 id_gpr_port_b  input  5  ID source register B.
REQ-006 id_uses_a, id_uses_b  input  1 each  the ID instruction reads port A / port B.
REQ-007 id_gpr_wa  input  5  ID destination register.
REQ-008 id_gpr_we  input  1  the ID instruction writes the GPR file.
REQ-009 id_mem_read  input  1  the ID instruction is a load.
REQ-010 mem_stall_req  input  1  data memory not ready; the whole pipeline freezes.
REQ-011 exc_flush  input  1  an exception is taken; kill the in-flight instructions.
REQ-012 forward_port_a_select, forward_port_b_select  output  2 each  operand source: 00 GPR, 01 EX, 10 MEM, 11 WB.
REQ-013 if_stall, id_stall  output  1 each  hold the PC / hold the IF-ID register.
REQ-014 ex_bubble  output  1  load a NOP into the ID-EX register this cycle.
REQ-015 ex_stall, mem_stall  output  1 each  hold the ID-EX / EX-MEM registers.
REQ-016 stall_cycles  output  32  saturating count of cycles with id_stall=1.
REQ-017 hazard_events  output  16  saturating count of rising edges of hazard (REQ-021).

Function
REQ-018 The block SHALL hold three stage records, EX, MEM and WB, each holding {wa[4:0], we, ld}.
REQ-019 Stage-record advance on each clock edge:
- mem_stall_req=1: all records hold.
- Else, exc_flush=1: EX, MEM and WB all take the bubble value {0,0,0}.
- Else, hazard=1: EX takes the bubble, MEM<=EX, WB<=MEM.
- Otherwise: EX<={id_gpr_wa, id_gpr_we, id_mem_read}, MEM<=EX, WB<=MEM.
REQ-020 A source X (A or B) matches stage S when id_uses_X=1, S.we=1, S.wa==source and source!=0.
REQ-021 hazard (combinational):
- With ENABLE_FWD=1: 1 iff a used source matches EX and EX.ld=1.
- With ENABLE_FWD=0: 1 iff a used source matches EX, MEM or WB.
REQ-022 Forward select per port, with ENABLE_FWD=1, by priority:
- EX match with EX.ld=0 -> 01;
- else MEM match -> 10;
- else WB match -> 11;
- else 00.
REQ-023 With ENABLE_FWD=0, both forward selects SHALL be constantly 00.
REQ-024 Forward select encoding when a source matches EX with EX.ld=1: the port SHALL NOT select 01; it falls through to the MEM/WB/GPR rules, and hazard=1.
REQ-025 Stall outputs:
- if_stall = id_stall = mem_stall_req | hazard.
- ex_stall = mem_stall = mem_stall_req.
- ex_bubble = hazard & ~mem_stall_req & ~exc_flush.
REQ-026 exc_flush and hazard in the same cycle: exc_flush SHALL win; the records clear and ex_bubble=0.
REQ-027 Register 0 SHALL never match, forward, or cause a stall.
REQ-028 stall_cycles SHALL increment by 1 on each edge where id_stall=1, and stop at 32'hFFFFFFFF.
REQ-029 hazard_events SHALL increment when hazard=1 while the registered hazard value of the previous cycle is 0, and stop at 16'hFFFF.
REQ-030 A stall-only cycle (mem_stall_req=1) SHALL NOT count as a hazard event.
REQ-031 Output latency: all forward and stall outputs SHALL be combinational from the current inputs and records, with zero-cycle latency.

Reset
REQ-032 While rst=1, all stage records, both counters and the registered previous-hazard value SHALL be 0.
REQ-033 Consequently, during and after reset the forward selects SHALL be 00 and the stall and bubble outputs SHALL be 0, unless mem_stall_req=1.
REQ-034 Reset asserted mid-stall SHALL clear the records immediately, with no clock edge required.

Verification
REQ-035 ALU chain:
- Stimulus: ID writes r3; next cycle ID reads A=r3.
- Response: forward_port_a_select=01, no stall.
- One cycle later the select is 10; two cycles later it is 11.
REQ-036 Load-use:
- Stimulus: ID is a load to r5; next cycle ID reads B=r5.
- Response: id_stall=1 and ex_bubble=1 for exactly 1 cycle, then forward_port_b_select=10.
- stall_cycles=1, hazard_events=1.
REQ-037 r0:
- Stimulus: ID writes r0 (we=1); next cycle ID reads r0.
- Response: both selects 00, no stall.
REQ-038 Memory freeze:
- Stimulus: mem_stall_req=1 for 3 cycles during the ALU chain.
- Response: the records hold; forward_port_a_select stays 01 for all 3 cycles; stall_cycles increases by 3; hazard_events is unchanged.
REQ-039 Flush plus reset:
- Stimulus: exc_flush coincident with a load-use hazard.
- Response: ex_bubble=0 and all records clear; on the next cycle the selects are 00.
- Then assert rst asynchronously: the counters read 0 without any clock edge.
REQ-040 ENABLE_FWD=0:
- Stimulus: r7 written, then read on the next cycle.
- Response: id_stall=1 for 3 cycles, then released; the selects stay 00 throughout.
